// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Groups the request/response handshake of the load/store unit and its
//   word-addressed data memory port.
//   Modports:
//     master : requester side (pipeline / testbench). It drives req_* and
//              mem_rdata, and observes req_ready, resp_* and mem_*.
//     slave  : the load_store_unit itself.
//   Signals:
//     req_valid/req_ready          request handshake
//     req_we, req_funct3           access type (store flag, RISC-V funct3)
//     req_addr, req_wdata          byte address, LSB-aligned store data
//     resp_valid/resp_rdata/resp_err   completion pulse, load data, error flag
//     mem_valid/mem_we/mem_addr/mem_wdata/mem_byte_enable  memory beat
//     mem_rdata                    combinational read data for mem_addr
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;

   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;

   logic            mem_valid;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_byte_enable;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   MEM-stage initiator for a word-addressed data memory. Converts RV32
//   LB/LH/LW/LBU/LHU/SB/SH/SW into one or two memory beats (lane shift and
//   byte enables) and sign/zero-extends load data.
//   Ports:
//     clk  : clock, all state changes on posedge
//     rst  : synchronous active-high reset; aborts any access in flight
//     bus  : load_store_unit_if.slave (request, response, memory port)
//   Configuration macro:
//     LSU_MISALIGN_SPLIT_EN : when defined, word-crossing accesses are split
//       into two beats (ACC1 then ACC2). When undefined, a crossing access is
//       answered with resp_err=1 and no memory beat.
//   FSM: IDLE -> ACC1 [-> ACC2] -> RESP -> IDLE, or IDLE -> RESP on error.
// -----------------------------------------------------------------------------
module load_store_unit (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus
);
   localparam int XLEN = 32;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            we_q, we_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
   logic            resp_err_q, resp_err_d;

   // Access size in bytes: 1, 2 or 4 (funct3[1:0]=11 only occurs on errors).
   function automatic logic [3:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 4'd1;
         2'b01:   size_of = 4'd2;
         default: size_of = 4'd4;
      endcase
   endfunction

   function automatic logic crosses(input logic [2:0] f3, input logic [1:0] o);
      crosses = ({2'b00, o} + size_of(f3)) > 4'd4;
   endfunction

   function automatic logic illegal(input logic we, input logic [2:0] f3);
      if (we) illegal = f3[2] || (f3[1:0] == 2'b11);
      else    illegal = (f3[1:0] == 2'b11) || (f3 == 3'b110);
   endfunction

   // Align the two captured words to the requested byte, then truncate and
   // extend according to size and funct3[2] (1 = unsigned).
   function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo,
                                                input logic [1:0]      o,
                                                input logic [2:0]      f3);
      logic [2*XLEN-1:0] cat;
      cat = {hi, lo} >> {o, 3'b000};
      case (f3[1:0])
         2'b00:   extract = f3[2] ? {24'b0, cat[7:0]}  : {{24{cat[7]}},  cat[7:0]};
         2'b01:   extract = f3[2] ? {16'b0, cat[15:0]} : {{16{cat[15]}}, cat[15:0]};
         default: extract = cat[XLEN-1:0];
      endcase
   endfunction

   // Decode of the latched request.
   logic [1:0]      o_l;
   logic            cross_l;
   logic [7:0]      lanes_l;
   logic [XLEN-1:0] base_addr;

   assign o_l       = addr_q[1:0];
   assign cross_l   = crosses(funct3_q, o_l);
   assign lanes_l   = ((size_of(funct3_q) == 4'd1) ? 8'h01 :
                       (size_of(funct3_q) == 4'd2) ? 8'h03 : 8'h0F) << o_l;
   assign base_addr = {addr_q[XLEN-1:2], 2'b00};

   // Next-state and result computation.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d   = bus.req_addr;
               we_d     = bus.req_we;
               funct3_d = bus.req_funct3;
               wdata_d  = bus.req_wdata;
               if (illegal(bus.req_we, bus.req_funct3) ||
                   (!SPLIT_EN && crosses(bus.req_funct3, bus.req_addr[1:0]))) begin
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = RESP;
               end else begin
                  state_d = ACC1;
               end
            end
         end
         ACC1: begin
            if (SPLIT_EN && cross_l) begin
               lo_d    = bus.mem_rdata;
               state_d = ACC2;
            end else begin
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? '0 : extract('0, bus.mem_rdata, o_l, funct3_q);
               state_d      = RESP;
            end
         end
         ACC2: begin
            resp_err_d   = 1'b0;
            resp_rdata_d = we_q ? '0 : extract(bus.mem_rdata, lo_q, o_l, funct3_q);
            state_d      = RESP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         lo_q         <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Memory beat. rst gates mem_valid combinationally so that no write can
   // happen in a cycle where reset is asserted (memory writes on negedge).
   logic beat;
   assign beat = ((state_q == ACC1) || (state_q == ACC2)) && !rst;

   assign bus.mem_valid       = beat;
   assign bus.mem_we          = we_q && beat;
   assign bus.mem_addr        = !beat ? '0 :
                                (state_q == ACC2) ? base_addr + 32'd4 : base_addr;
   assign bus.mem_byte_enable = !beat ? 4'b0000 :
                                (state_q == ACC2) ? lanes_l[7:4] : lanes_l[3:0];
   assign bus.mem_wdata       = !beat ? '0 :
                                (state_q == ACC2) ? wdata_q >> (6'd32 - {1'b0, o_l, 3'b000})
                                                  : wdata_q << {o_l, 3'b000};

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign bus.resp_valid = (state_q == RESP) && !rst;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Table-driven bench for load_store_unit with a behavioural word memory
//   (combinational read, byte-enabled write on negedge) plus hand-written
//   sequences for reset-abort and a held req_valid.
//   Expectations for word-crossing accesses depend on LSU_MISALIGN_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.XLEN(32)) bus ();

   load_store_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural memory: 64 words, combinational read, negedge write.
   logic [31:0] mem [0:63] = '{default: 32'h0};
   logic [31:0] beat_addr [0:63];
   logic [3:0]  beat_be   [0:63];
   logic [31:0] beat_wd   [0:63];
   int          total_beats = 0;
   int          poke_seq = 0, poke_done = 0, poke_idx = 0;
   logic [31:0] poke_val = 32'h0;

   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   always @(negedge clk) begin
      if (poke_seq != poke_done) begin
         mem[poke_idx] = poke_val;
         poke_done     = poke_seq;
      end
      if (bus.mem_valid) begin
         beat_addr[total_beats & 63] = bus.mem_addr;
         beat_be[total_beats & 63]   = bus.mem_byte_enable;
         beat_wd[total_beats & 63]   = bus.mem_wdata;
         total_beats = total_beats + 1;
         if (bus.mem_we)
            for (int b = 0; b < 4; b++)
               if (bus.mem_byte_enable[b])
                  mem[bus.mem_addr[7:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      poke_idx = idx;
      poke_val = val;
      poke_seq = poke_seq + 1;
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_beats;
      logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0;
      logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input string n, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input int lat, input int nb,
                      input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                      input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1);
      vec_t v;
      v.name = n; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
      v.exp_err = err; v.exp_rdata = rd; v.exp_lat = lat; v.exp_beats = nb;
      v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
      vecs.push_back(v);
   endtask

   // One access: present the request for one cycle, scramble the request
   // inputs after accept (they must be latched), then wait for resp_valid.
   task automatic run_access(input vec_t v, output int lat, output logic err,
                             output logic [31:0] rdata, output int nbeats);
      int start;
      @(posedge clk);
      #1;
      start          = total_beats;
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = ~v.we;
      bus.req_funct3 = 3'b111;
      bus.req_addr   = 32'hFFFF_FFFC;
      bus.req_wdata  = 32'h5A5A_5A5A;
      lat = 0; err = 1'bx; rdata = 'x;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat   = c;
            err   = bus.resp_err;
            rdata = bus.resp_rdata;
         end
      end
      nbeats = total_beats - start;
   endtask

   int          lat, nb, cnt, start;
   logic        err;
   logic [31:0] rd;

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      //   name        we  f3    addr   wdata        err rdata        lat nb  beat0                      beat1
      add("SW_10",     1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0);
      add("LW_10",     0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 1, 32'h10, 4'hF, 32'h0,        0, 0, 0);
      add("SB_13",     1, 3'b000, 32'h13, 32'h000000A5, 0, 32'h0,        2, 1, 32'h10, 4'h8, 32'hA5000000, 0, 0, 0);
      add("LB_13",     0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFA5, 2, 1, 32'h10, 4'h8, 32'h0,        0, 0, 0);
      add("LBU_13",    0, 3'b100, 32'h13, 32'h0,        0, 32'h000000A5, 2, 1, 32'h10, 4'h8, 32'h0,        0, 0, 0);
      add("LH_11",     0, 3'b001, 32'h11, 32'h0,        0, 32'hFFFFADBE, 2, 1, 32'h10, 4'h6, 32'h0,        0, 0, 0);
      add("LBU_12",    0, 3'b100, 32'h12, 32'h0,        0, 32'h000000AD, 2, 1, 32'h10, 4'h4, 32'h0,        0, 0, 0);
      add("SH_22",     1, 3'b001, 32'h22, 32'h00008234, 0, 32'h0,        2, 1, 32'h20, 4'hC, 32'h82340000, 0, 0, 0);
      add("LH_22",     0, 3'b001, 32'h22, 32'h0,        0, 32'hFFFF8234, 2, 1, 32'h20, 4'hC, 32'h0,        0, 0, 0);
      add("LHU_22",    0, 3'b101, 32'h22, 32'h0,        0, 32'h00008234, 2, 1, 32'h20, 4'hC, 32'h0,        0, 0, 0);
      add("LD011_20",  0, 3'b011, 32'h20, 32'h0,        1, 32'h0,        1, 0, 0, 0, 0,                    0, 0, 0);
      add("ST011_20",  1, 3'b011, 32'h20, 32'h12345678, 1, 32'h0,        1, 0, 0, 0, 0,                    0, 0, 0);
      add("LD110_20",  0, 3'b110, 32'h20, 32'h0,        1, 32'h0,        1, 0, 0, 0, 0,                    0, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
      add("SW_0E",     1, 3'b010, 32'h0E, 32'h11223344, 0, 32'h0,        3, 2, 32'h0C, 4'hC, 32'h33440000, 32'h10, 4'h3, 32'h00001122);
      add("LW_0E",     0, 3'b010, 32'h0E, 32'h0,        0, 32'h11223344, 3, 2, 32'h0C, 4'hC, 32'h0,        32'h10, 4'h3, 32'h0);
`else
      add("SW_0E",     1, 3'b010, 32'h0E, 32'h11223344, 1, 32'h0,        1, 0, 0, 0, 0,                    0, 0, 0);
      add("LW_0E",     0, 3'b010, 32'h0E, 32'h0,        1, 32'h0,        1, 0, 0, 0, 0,                    0, 0, 0);
`endif

      // Reset state.
      @(negedge clk);
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("rst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready_after", {31'b0, bus.req_ready}, 32'h1);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
      $display("reset: req_ready=%0b resp_rdata=0x%08h resp_err=%0b",
               bus.req_ready, bus.resp_rdata, bus.resp_err);

      foreach (vecs[i]) begin
         run_access(vecs[i], lat, err, rd, nb);
         $display("%s: lat=%0d err=%0b rdata=0x%08h beats=%0d", vecs[i].name, lat, err, rd, nb);
         check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
         check({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, "_beats"}, nb, vecs[i].exp_beats);
         if (vecs[i].exp_beats >= 1 && nb >= 1) begin
            check({vecs[i].name, "_b0_addr"}, beat_addr[(total_beats - nb) & 63], vecs[i].a0);
            check({vecs[i].name, "_b0_be"}, {28'b0, beat_be[(total_beats - nb) & 63]}, {28'b0, vecs[i].be0});
            check({vecs[i].name, "_b0_wdata"}, beat_wd[(total_beats - nb) & 63], vecs[i].wd0);
         end
         if (vecs[i].exp_beats >= 2 && nb >= 2) begin
            check({vecs[i].name, "_b1_addr"}, beat_addr[(total_beats - nb + 1) & 63], vecs[i].a1);
            check({vecs[i].name, "_b1_be"}, {28'b0, beat_be[(total_beats - nb + 1) & 63]}, {28'b0, vecs[i].be1});
            check({vecs[i].name, "_b1_wdata"}, beat_wd[(total_beats - nb + 1) & 63], vecs[i].wd1);
         end
      end

      // Reset during ACC1 of an aligned store: no write, no response.
      poke(4, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h10; bus.req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort1_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
      check("abort1_req_ready", {31'b0, bus.req_ready}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      cnt = 0;
      @(negedge clk);
      check("abort1_ready_after", {31'b0, bus.req_ready}, 32'h1);
      for (int c = 0; c < 4; c++) begin
         if (bus.resp_valid) cnt++;
         @(negedge clk);
      end
      check("abort1_no_resp", cnt, 0);
      check("abort1_word10", mem[4], 32'hCAFEF00D);
      check("abort1_resp_err_clr", {31'b0, bus.resp_err}, 32'h0);
      $display("abort_acc1: resp_pulses=%0d word10=0x%08h", cnt, mem[4]);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Reset during ACC2 of a crossing store: first beat stays, second never happens.
      poke(3, 32'h0);
      poke(4, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h0E; bus.req_wdata = 32'h55667788;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort2_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort2_req_ready", {31'b0, bus.req_ready}, 32'h1);
      check("abort2_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("abort2_word10", mem[4], 32'hCAFEF00D);
      check("abort2_word0c", mem[3], 32'h77880000);
      $display("abort_acc2: word0c=0x%08h word10=0x%08h", mem[3], mem[4]);
`endif

      // req_valid held high while busy: exactly one access and one response.
      @(posedge clk);
      #1;
      start = total_beats;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h0;
      @(posedge clk);
      cnt = 0;
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = c;
            cnt++;
            rd = bus.resp_rdata;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.resp_valid) cnt++;
      end
      $display("held_valid: lat=%0d resp_pulses=%0d beats=%0d rdata=0x%08h",
               lat, cnt, total_beats - start, rd);
      check("held_lat", lat, 2);
      check("held_resp_pulses", cnt, 1);
      check("held_beats", total_beats - start, 1);
      check("held_rdata", rd, 32'h82340000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
